// File: rtl/approx_mult_seq.sv
// ============================================================================
// Module      : approx_mult_seq (with helper approx_8x8)
// Description : Sequential W x W unsigned multiplier built from a single
//               time-multiplexed 8x8 partial-product unit. The precise mode
//               sums the shifted partial products and gives the exact product.
//               The approximate mode ORs them together, so no carries
//               propagate between partial products.
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready   : operand handshake (a, b, precise_en)
//               out_valid / out_ready : result handshake (y, 2W bits)
// Option      : `define APPROX_MULT_SKIP_LSB_EN so that the approximate mode
//               skips the least-significant partial product (i = j = 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// approx_8x8: 8x8 multiplier. In exact mode it returns a*b. In approximate
// mode it ORs the partial-product rows instead of adding them.
// Ports: a_i, b_i (8b operands), precise_en_i (1 = exact), p_o (16b result)
// ----------------------------------------------------------------------------
module approx_8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        precise_en_i,
  output logic [15:0] p_o
);

  logic [15:0] or_rows;

  always_comb begin
    or_rows = '0;
    for (int k = 0; k < 8; k++) begin
      if (b_i[k]) begin
        or_rows = or_rows | ({8'h00, a_i} << k);
      end
    end
  end

  assign p_o = precise_en_i ? ({8'h00, a_i} * {8'h00, b_i}) : or_rows;

endmodule

// ----------------------------------------------------------------------------
// approx_mult_seq: top level
// ----------------------------------------------------------------------------
module approx_mult_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           precise_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
);

  localparam int K   = W / 8;
  localparam int NPP = K * K;
  localparam int PW  = $clog2(NPP + 1);
  localparam int IW  = $clog2(K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] y_q, y_d;
  logic [PW-1:0]  p_q, p_d;
  // i and j are kept as separate counters so that p / K and p mod K never
  // need a divider when K is not a power of two.
  logic [IW-1:0]  i_q, i_d;
  logic [IW-1:0]  j_q, j_d;

  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic [15:0]    pp;
  logic [2*W-1:0] pp_shifted;
  logic [2*W-1:0] acc_next;
  logic           skip_first;

  assign a_byte = a_q[8*i_q +: 8];
  assign b_byte = b_q[8*j_q +: 8];

  approx_8x8 u_pp (
    .a_i          (a_byte),
    .b_i          (b_byte),
    .precise_en_i (mode_q),
    .p_o          (pp)
  );

  assign pp_shifted = {{(2*W-16){1'b0}}, pp} << (8 * (int'(i_q) + int'(j_q)));
  assign acc_next   = mode_q ? (acc_q + pp_shifted) : (acc_q | pp_shifted);

`ifdef APPROX_MULT_SKIP_LSB_EN
  // The approximate mode starts at p = 1, which is (i, j) = (0, 1).
  assign skip_first = ~precise_en;
`else
  assign skip_first = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      y_q    <= '0;
      p_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
      p_q    <= p_d;
      i_q    <= i_d;
      j_q    <= j_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    y_d     = y_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = precise_en;
          acc_d   = '0;
          i_d     = '0;
          p_d     = skip_first ? PW'(1) : '0;
          j_d     = skip_first ? IW'(1) : '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        acc_d = acc_next;
        if (p_q == PW'(NPP - 1)) begin
          y_d     = acc_next;
          state_d = DONE;
        end else begin
          p_d = p_q + PW'(1);
          if (j_q == IW'(K - 1)) begin
            j_d = '0;
            i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          p_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

`default_nettype wire

// File: doc/approx_mult_seq.md
APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 SHALL have parameter W, default 16, operand width in bits; legal values 16, 24, 32, 40, 48, 56, 64 (multiple of 8); derived K = W/8, NPP = K*K.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  multiplicand, unsigned.
REQ-007 SHALL have port b  input  W  multiplier, unsigned.
REQ-008 SHALL have port precise_en  input  1  1 = exact product, 0 = approximate product; sampled with operands.
REQ-009 SHALL have port out_valid  output  1  result y valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts y.
REQ-011 SHALL have port y  output  2W  product.

Function
REQ-012 SHALL time-multiplex one instance of the existing approx_8x8 block (precise_en driven from the latched mode) to form all NPP 8x8 partial products.
REQ-013 SHALL use FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept on a rising edge with in_valid & in_ready: latch a, b and precise_en; clear the 2W-bit accumulator; set counter p = 0; go to BUSY.
REQ-015 SHALL, in BUSY on each edge, compute pp = approx_8x8(a byte i, b byte j) with i = p / K and j = p mod K, and shift it left by 8*(i+j).
REQ-016 SHALL, in precise mode, update acc = acc + shifted pp; the final y equals the exact a*b.
REQ-017 SHALL, in approximate mode, update acc = acc | shifted pp, with no carries between partial products.
REQ-018 SHALL increment p after each partial product; after the edge that processes p = NPP-1, go to DONE with y = acc.
REQ-019 SHALL raise out_valid exactly NPP edges after the accepting edge in default configuration.
REQ-020 SHALL hold y and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-021 SHALL ignore changes on a, b and precise_en outside the accepting edge.
REQ-022 SHALL not accept a new operand in BUSY or DONE; maximum throughput is one product per NPP+2 cycles.
REQ-023 SHALL hold y at the last result in IDLE.

Reset
REQ-024 SHALL, while rst_n = 0, immediately force state IDLE, p = 0, acc = 0, y = 0, out_valid = 0, and latched mode = 0, regardless of clk.
REQ-025 SHALL discard any in-flight transaction on reset mid-BUSY or mid-DONE, with no output produced; in_ready = 1 on the first cycle after release.

Configuration
REQ-026 SHALL, when macro APPROX_MULT_SKIP_LSB_EN is defined, skip partial product p = 0 (i = j = 0) in approximate mode only: BUSY starts at p = 1 and out_valid rises NPP-1 edges after acceptance.
REQ-027 SHALL, without APPROX_MULT_SKIP_LSB_EN, process all NPP partial products in both modes; precise mode is identical with or without the macro.

Verification
REQ-028 SHALL pass: W=16, precise, a=0xFFFF, b=0xFFFF -> y=0xFFFE0001, out_valid 4 edges after accept.
REQ-029 SHALL pass: W=16, approx, a=0x0100, b=0x0100 -> y=0x00010000; a=0x0003, b=0x0003 -> y=0x00000007 without the macro and y=0x00000000 (3 edges) with it.
REQ-030 SHALL pass: W=32, precise, a=0x12345678, b=0x9ABCDEF0 -> y=0x0B00EA4E242D2080, out_valid 16 edges after accept.
REQ-031 SHALL pass: out_ready held 0 for 5 cycles in DONE -> y and out_valid stable, in_ready = 0; out_ready = 1 -> IDLE on the next edge.
REQ-032 SHALL pass: rst_n pulsed low mid-BUSY -> out_valid = 0 and y = 0 immediately, no result emitted; the next transaction (precise, 0x0002*0x0003) -> y=0x00000006.
REQ-033 SHALL pass: a/b/precise_en toggled randomly during BUSY -> result matches the operands latched at acceptance.
